// File: rtl/sb_pkg.sv
// Shared widths, drain FSM encoding and the per-entry record for the store buffer.
package sb_pkg;

    localparam int SB_SIZE = 5;
    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 16;
    localparam int NUM_ENT = 2 ** SB_SIZE;
    localparam int CNT_W   = SB_SIZE + 1;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } drain_state_e;

    typedef struct packed {
        logic              busy;
        logic              ready;
        logic              commit;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/sb_fwd_search.sv
// Load-forwarding search: the youngest busy+ready entry whose address matches wins.
module sb_fwd_search
    import sb_pkg::*;
(
    input  sb_entry_t          ent_i [NUM_ENT],
    input  logic [SB_SIZE-1:0] tail_i,
    input  logic [ADDR_W-1:0]  ld_addr_i,
    output logic               hit_o,
    output logic [DATA_W-1:0]  data_o
);

    // Walk from oldest to youngest (tail-32 .. tail-1) so the last match taken is the youngest.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        for (int j = NUM_ENT - 1; j >= 0; j--) begin
            logic [SB_SIZE-1:0] idx;
            idx = tail_i - SB_SIZE'(1) - SB_SIZE'(j);
            if (ent_i[idx].busy && ent_i[idx].ready && ent_i[idx].addr == ld_addr_i) begin
                hit_o  = 1'b1;
                data_o = ent_i[idx].data;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Store buffer: holds stores from dispatch until ROB retire, then drains them in order
// through a req/ack memory write port. Also forwards store data to younger loads.
module store_buffer
    import sb_pkg::*;
(
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               Flush,
    input  logic               Alloc1_V,
    input  logic               Alloc2_V,
    output logic [SB_SIZE-1:0] SB_Addr1,
    output logic [SB_SIZE-1:0] SB_Addr2,
    output logic               SB_stall,
    input  logic               LSU_St_V,
    input  logic [SB_SIZE-1:0] LSU_St_Index,
    input  logic [ADDR_W-1:0]  LSU_St_Addr,
    input  logic [DATA_W-1:0]  LSU_St_Data,
    input  logic [ADDR_W-1:0]  LSU_Ld_Addr,
    output logic               SB_Fwd_Hit,
    output logic [DATA_W-1:0]  SB_Fwd_Data,
    input  logic               ROB_Retire1_SB_V,
    input  logic [SB_SIZE-1:0] ROB_Retire1_SB_Addr,
    input  logic               ROB_Retire2_SB_V,
    input  logic [SB_SIZE-1:0] ROB_Retire2_SB_Addr,
    output logic               Mem_Wr_Req,
    output logic [ADDR_W-1:0]  Mem_Wr_Addr,
    output logic [DATA_W-1:0]  Mem_Wr_Data,
    input  logic               Mem_Wr_Ack
);

    sb_entry_t          ent_q [NUM_ENT];
    sb_entry_t          ent_d [NUM_ENT];
    logic [SB_SIZE-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d, ncommit;
    drain_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]  wr_data_q, wr_data_d;
    logic               a1, a2, ack, go;

    assign SB_Addr1 = tail_q;
    assign SB_Addr2 = tail_q + SB_SIZE'(1);
    assign SB_stall = count_q >= CNT_W'(NUM_ENT - 1);

    assign a1  = Alloc1_V & ~SB_stall & ~Flush;
    assign a2  = Alloc2_V & ~SB_stall & ~Flush;
    assign ack = (state_q == REQ) & Mem_Wr_Ack;
    assign go  = ent_q[head_q].busy & ent_q[head_q].commit & ent_q[head_q].ready;

    // Drain FSM: state register / next state / outputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (go) state_d = REQ;
            REQ:     if (Mem_Wr_Ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        Mem_Wr_Req = (state_q == REQ);
    end

    assign Mem_Wr_Addr = wr_addr_q;
    assign Mem_Wr_Data = wr_data_q;
    assign wr_addr_d   = (state_q == IDLE && go) ? ent_q[head_q].addr : wr_addr_q;
    assign wr_data_d   = (state_q == IDLE && go) ? ent_q[head_q].data : wr_data_q;

    // Entry array and pointer update; retire is applied before flush so it survives it
    always_comb begin
        ent_d   = ent_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        ncommit = '0;

        if (LSU_St_V && !Flush && ent_q[LSU_St_Index].busy) begin
            ent_d[LSU_St_Index].addr  = LSU_St_Addr;
            ent_d[LSU_St_Index].data  = LSU_St_Data;
            ent_d[LSU_St_Index].ready = 1'b1;
        end
        if (ROB_Retire1_SB_V) ent_d[ROB_Retire1_SB_Addr].commit = 1'b1;
        if (ROB_Retire2_SB_V) ent_d[ROB_Retire2_SB_Addr].commit = 1'b1;

        for (int i = 0; i < NUM_ENT; i++)
            ncommit = ncommit + CNT_W'(ent_d[i].busy & ent_d[i].commit);

        if (a1) begin
            ent_d[tail_q].busy   = 1'b1;
            ent_d[tail_q].ready  = 1'b0;
            ent_d[tail_q].commit = 1'b0;
        end
        if (a2) begin
            ent_d[SB_Addr2].busy   = 1'b1;
            ent_d[SB_Addr2].ready  = 1'b0;
            ent_d[SB_Addr2].commit = 1'b0;
        end

        if (ack) begin
            ent_d[head_q] = '0;
            head_d        = head_q + SB_SIZE'(1);
        end

        if (Flush) begin
            for (int i = 0; i < NUM_ENT; i++) begin
                if (!ent_d[i].commit) begin
                    ent_d[i].busy  = 1'b0;
                    ent_d[i].ready = 1'b0;
                end
            end
            tail_d  = head_q + ncommit[SB_SIZE-1:0];
            count_d = ncommit - CNT_W'(ack);
        end else begin
            tail_d  = tail_q + SB_SIZE'(a1) + SB_SIZE'(a2);
            count_d = count_q + CNT_W'(a1) + CNT_W'(a2) - CNT_W'(ack);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NUM_ENT; i++) ent_q[i] <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            ent_q     <= ent_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    sb_fwd_search u_fwd (
        .ent_i     (ent_q),
        .tail_i    (tail_q),
        .ld_addr_i (LSU_Ld_Addr),
        .hit_o     (SB_Fwd_Hit),
        .data_o    (SB_Fwd_Data)
    );

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: expected memory writes go into a scoreboard queue
// and a memory responder pops and compares them on every write handshake.
module tb_store_buffer;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        Flush = 1'b0, Alloc1_V = 1'b0, Alloc2_V = 1'b0;
    logic [4:0]  SB_Addr1, SB_Addr2;
    logic        SB_stall;
    logic        LSU_St_V = 1'b0;
    logic [4:0]  LSU_St_Index = '0;
    logic [15:0] LSU_St_Addr = '0, LSU_St_Data = '0, LSU_Ld_Addr = '0;
    logic        SB_Fwd_Hit;
    logic [15:0] SB_Fwd_Data;
    logic        ROB_Retire1_SB_V = 1'b0, ROB_Retire2_SB_V = 1'b0;
    logic [4:0]  ROB_Retire1_SB_Addr = '0, ROB_Retire2_SB_Addr = '0;
    logic        Mem_Wr_Req;
    logic [15:0] Mem_Wr_Addr, Mem_Wr_Data;
    logic        Mem_Wr_Ack = 1'b0;

    store_buffer dut (
        .CLK(CLK), .RST_N(RST_N), .Flush(Flush), .Alloc1_V(Alloc1_V), .Alloc2_V(Alloc2_V),
        .SB_Addr1(SB_Addr1), .SB_Addr2(SB_Addr2), .SB_stall(SB_stall),
        .LSU_St_V(LSU_St_V), .LSU_St_Index(LSU_St_Index), .LSU_St_Addr(LSU_St_Addr),
        .LSU_St_Data(LSU_St_Data), .LSU_Ld_Addr(LSU_Ld_Addr),
        .SB_Fwd_Hit(SB_Fwd_Hit), .SB_Fwd_Data(SB_Fwd_Data),
        .ROB_Retire1_SB_V(ROB_Retire1_SB_V), .ROB_Retire1_SB_Addr(ROB_Retire1_SB_Addr),
        .ROB_Retire2_SB_V(ROB_Retire2_SB_V), .ROB_Retire2_SB_Addr(ROB_Retire2_SB_Addr),
        .Mem_Wr_Req(Mem_Wr_Req), .Mem_Wr_Addr(Mem_Wr_Addr), .Mem_Wr_Data(Mem_Wr_Data),
        .Mem_Wr_Ack(Mem_Wr_Ack)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t sbq[$];
    int  n_pass = 0, n_total = 0;
    int  ack_delay = 0;
    bit  resp_busy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        {Flush, Alloc1_V, Alloc2_V, LSU_St_V, ROB_Retire1_SB_V, ROB_Retire2_SB_V} = '0;
        sbq.delete();
        step();
        step();
        RST_N = 1'b1;
    endtask

    task automatic alloc(input bit x1, input bit x2);
        Alloc1_V = x1; Alloc2_V = x2;
        step();
        Alloc1_V = 1'b0; Alloc2_V = 1'b0;
    endtask

    task automatic fill(input logic [4:0] idx, input logic [15:0] a, input logic [15:0] d);
        LSU_St_V = 1'b1; LSU_St_Index = idx; LSU_St_Addr = a; LSU_St_Data = d;
        step();
        LSU_St_V = 1'b0;
    endtask

    task automatic retire(input bit v1, input logic [4:0] i1, input bit v2, input logic [4:0] i2);
        ROB_Retire1_SB_V = v1; ROB_Retire1_SB_Addr = i1;
        ROB_Retire2_SB_V = v2; ROB_Retire2_SB_Addr = i2;
        step();
        ROB_Retire1_SB_V = 1'b0; ROB_Retire2_SB_V = 1'b0;
    endtask

    task automatic expect_wr(input logic [15:0] a, input logic [15:0] d);
        wr_t w;
        w.addr = a; w.data = d;
        sbq.push_back(w);
    endtask

    task automatic wait_drain(input string name);
        int k;
        for (k = 0; k < 400; k++) begin
            if (sbq.size() == 0 && !resp_busy && !Mem_Wr_Req) break;
            @(negedge CLK);
        end
        if (k == 400) check({name, "_drain_timeout"}, 32'(sbq.size()), 32'd0);
    endtask

    // Memory responder / scoreboard monitor
    initial begin
        wr_t         w;
        logic [15:0] a0, d0;
        bit          stable, aborted;
        forever begin
            @(negedge CLK);
            if (RST_N && Mem_Wr_Req) begin
                resp_busy = 1'b1;
                a0 = Mem_Wr_Addr; d0 = Mem_Wr_Data;
                stable = 1'b1; aborted = 1'b0;
                for (int k = 0; k < ack_delay; k++) begin
                    @(negedge CLK);
                    if (!RST_N) begin aborted = 1'b1; break; end
                    if (Mem_Wr_Req !== 1'b1 || Mem_Wr_Addr !== a0 || Mem_Wr_Data !== d0) stable = 1'b0;
                end
                if (!aborted) begin
                    if (ack_delay > 0) check("req_stable", 32'(stable), 32'd1);
                    if (sbq.size() == 0) begin
                        check("unexpected_write_addr", 32'(a0), 32'hFFFF_FFFF);
                    end else begin
                        w = sbq.pop_front();
                        check("wr_addr", 32'(a0), 32'(w.addr));
                        check("wr_data", 32'(d0), 32'(w.data));
                    end
                    Mem_Wr_Ack = 1'b1;
                    @(negedge CLK);
                    Mem_Wr_Ack = 1'b0;
                    check("req_bubble", 32'(Mem_Wr_Req), 32'd0);
                end
                resp_busy = 1'b0;
            end
        end
    end

    initial begin
        // Reset values
        @(negedge CLK);
        #1;
        check("rst_req", 32'(Mem_Wr_Req), 0);
        check("rst_waddr", 32'(Mem_Wr_Addr), 0);
        check("rst_wdata", 32'(Mem_Wr_Data), 0);
        check("rst_stall", 32'(SB_stall), 0);
        check("rst_addr1", 32'(SB_Addr1), 0);
        check("rst_addr2", 32'(SB_Addr2), 1);
        check("rst_hit", 32'(SB_Fwd_Hit), 0);
        check("rst_fwd_data", 32'(SB_Fwd_Data), 0);
        @(negedge CLK);
        RST_N = 1'b1;

        // Dual allocation
        Alloc1_V = 1'b1; Alloc2_V = 1'b1;
        #1;
        check("alloc_pre_a1", 32'(SB_Addr1), 0);
        check("alloc_pre_a2", 32'(SB_Addr2), 1);
        step();
        Alloc1_V = 1'b0; Alloc2_V = 1'b0;
        check("alloc_post_a1", 32'(SB_Addr1), 2);
        check("alloc_post_a2", 32'(SB_Addr2), 3);
        check("alloc_count", 32'(dut.count_q), 2);

        // Single drain with ack held off
        ack_delay = 3;
        expect_wr(16'h0040, 16'hBEEF);
        fill(5'd0, 16'h0040, 16'hBEEF);
        retire(1'b1, 5'd0, 1'b0, 5'd0);
        wait_drain("single");
        check("single_head", 32'(dut.head_q), 1);
        check("single_count", 32'(dut.count_q), 1);

        // Forwarding: youngest match wins
        do_reset();
        alloc(1'b1, 1'b1);
        fill(5'd0, 16'h0010, 16'h1111);
        LSU_Ld_Addr = 16'h0010;
        #1;
        check("fwd_one_data", 32'(SB_Fwd_Data), 32'h1111);
        @(negedge CLK);
        fill(5'd1, 16'h0010, 16'h2222);
        #1;
        check("fwd_hit", 32'(SB_Fwd_Hit), 1);
        check("fwd_young_data", 32'(SB_Fwd_Data), 32'h2222);
        LSU_Ld_Addr = 16'h0020;
        #1;
        check("fwd_miss_hit", 32'(SB_Fwd_Hit), 0);
        check("fwd_miss_data", 32'(SB_Fwd_Data), 0);
        @(negedge CLK);

        // Full: 31 busy entries stalls, further allocation ignored
        do_reset();
        for (int i = 0; i < 15; i++) alloc(1'b1, 1'b1);
        check("full30_stall", 32'(SB_stall), 0);
        alloc(1'b1, 1'b0);
        check("full31_stall", 32'(SB_stall), 1);
        check("full31_tail", 32'(SB_Addr1), 31);
        alloc(1'b1, 1'b1);
        check("full_ign_tail", 32'(SB_Addr1), 31);
        check("full_ign_count", 32'(dut.count_q), 31);
        ack_delay = 0;
        expect_wr(16'h0100, 16'hA5A5);
        fill(5'd0, 16'h0100, 16'hA5A5);
        retire(1'b1, 5'd0, 1'b0, 5'd0);
        wait_drain("full");
        check("full_drain_stall", 32'(SB_stall), 0);
        check("full_drain_count", 32'(dut.count_q), 30);

        // Flush with same-cycle retire
        do_reset();
        alloc(1'b1, 1'b1);
        alloc(1'b1, 1'b1);
        alloc(1'b1, 1'b0);
        check("flush_pre_tail", 32'(SB_Addr1), 5);
        for (int i = 0; i < 3; i++) fill(5'(i), 16'h0200 + 16'(i), 16'h3000 + 16'(i));
        for (int i = 0; i < 3; i++) expect_wr(16'h0200 + 16'(i), 16'h3000 + 16'(i));
        ack_delay = 2;
        retire(1'b1, 5'd0, 1'b1, 5'd1);
        Flush = 1'b1; Alloc1_V = 1'b1;
        retire(1'b1, 5'd2, 1'b0, 5'd0);
        Flush = 1'b0; Alloc1_V = 1'b0;
        check("flush_tail", 32'(SB_Addr1), 3);
        check("flush_count", 32'(dut.count_q), 3);
        wait_drain("flush");
        check("flush_head", 32'(dut.head_q), 3);
        check("flush_end_count", 32'(dut.count_q), 0);

        // Wrap-around: bring head and tail to 30, then allocate across the boundary
        do_reset();
        ack_delay = 0;
        for (int i = 0; i < 15; i++) alloc(1'b1, 1'b1);
        for (int i = 0; i < 30; i++) fill(5'(i), 16'h0300 + 16'(i), 16'h7000 + 16'(i));
        for (int i = 0; i < 30; i++) expect_wr(16'h0300 + 16'(i), 16'h7000 + 16'(i));
        for (int i = 0; i < 30; i += 2) retire(1'b1, 5'(i), 1'b1, 5'(i + 1));
        wait_drain("prewrap");
        check("wrap_head0", 32'(dut.head_q), 30);
        check("wrap_tail0", 32'(SB_Addr1), 30);
        Alloc1_V = 1'b1; Alloc2_V = 1'b1;
        #1;
        check("wrap_a1_first", 32'(SB_Addr1), 30);
        check("wrap_a2_first", 32'(SB_Addr2), 31);
        step();
        check("wrap_a1_second", 32'(SB_Addr1), 0);
        check("wrap_a2_second", 32'(SB_Addr2), 1);
        step();
        Alloc1_V = 1'b0; Alloc2_V = 1'b0;
        check("wrap_count", 32'(dut.count_q), 4);
        fill(5'd30, 16'h0530, 16'hC030);
        fill(5'd31, 16'h0531, 16'hC031);
        fill(5'd0,  16'h0500, 16'hC000);
        fill(5'd1,  16'h0501, 16'hC001);
        expect_wr(16'h0530, 16'hC030);
        expect_wr(16'h0531, 16'hC031);
        expect_wr(16'h0500, 16'hC000);
        expect_wr(16'h0501, 16'hC001);
        retire(1'b1, 5'd30, 1'b1, 5'd31);
        retire(1'b1, 5'd0, 1'b1, 5'd1);
        wait_drain("wrap");
        check("wrap_head_end", 32'(dut.head_q), 2);

        // Asynchronous reset mid-request
        ack_delay = 20;
        alloc(1'b1, 1'b0);
        expect_wr(16'h0600, 16'h1234);
        fill(5'd2, 16'h0600, 16'h1234);
        retire(1'b1, 5'd2, 1'b0, 5'd0);
        step();
        check("mid_req_high", 32'(Mem_Wr_Req), 1);
        #2;
        RST_N = 1'b0;
        #1;
        check("mid_rst_req", 32'(Mem_Wr_Req), 0);
        sbq.delete();
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
